// File: rtl/interlock_out_ctrl.sv
// Break-before-make output interlock for pole and pair-switch drives; optional
// pole-count limit enabled by defining INTERLOCK_MAXON_EN.
module interlock_out_ctrl #(
  parameter int  N_POLE        = 8,
  parameter int  SETTLE_CYCLES = 500000,
  parameter int  STABLE_CYCLES = 4,
  parameter int  MAX_ON        = 2,
  localparam int N_PAIR        = N_POLE * (N_POLE - 1) / 2
) (
  input  logic              pclk_50M,
  input  logic              rst,
  input  logic [N_POLE-1:0] pole_req,
  input  logic [N_PAIR-1:0] pair_req,
  output logic [N_POLE-1:0] pole_out,
  output logic [N_PAIR-1:0] pair_out,
  output logic              busy,
  output logic              conflict
);

  localparam int W_REQ = N_POLE + N_PAIR;
  localparam int W_STB = $clog2(STABLE_CYCLES + 1);
  localparam int W_SET = $clog2(SETTLE_CYCLES + 1);
  localparam logic [W_STB-1:0] STABLE_MAX  = W_STB'(STABLE_CYCLES);
  localparam logic [W_SET-1:0] SETTLE_LAST = W_SET'(SETTLE_CYCLES - 1);

  if (N_POLE < 3 || N_POLE > 16 || SETTLE_CYCLES < 2 || STABLE_CYCLES < 1 || MAX_ON < 0)
  begin : g_param_check
    $error("interlock_out_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_OFF, S_WAIT, S_ON} state_t;

  state_t            r_state, w_state_nxt;
  logic [W_REQ-1:0]  r_req_q, r_applied;
  logic [W_STB-1:0]  r_stable_cnt;
  logic [W_SET-1:0]  r_settle_cnt;
  logic [N_POLE-1:0] r_pole_out;
  logic [N_PAIR-1:0] r_pair_out;

  logic [W_REQ-1:0]  w_req_in;
  logic [N_POLE-1:0] w_pole_q;
  logic [N_PAIR-1:0] w_pair_q, w_pair_clash, w_pair_off;
  logic              w_changed, w_stable;

  assign w_req_in  = {pole_req, pair_req};
  assign w_pole_q  = r_req_q[W_REQ-1 -: N_POLE];
  assign w_pair_q  = r_req_q[N_PAIR-1:0];
  assign w_changed = (w_req_in != r_req_q);
  assign w_stable  = (r_stable_cnt == STABLE_MAX);

  // A pair switch must never bridge two poles that are both requested on.
  for (genvar j = 1; j < N_POLE; j++) begin : g_pair_j
    for (genvar i = 0; i < j; i++) begin : g_pair_i
      assign w_pair_clash[j*(j-1)/2 + i] = w_pole_q[i] & w_pole_q[j];
    end
  end
  assign w_pair_off = (w_pole_q == '0) ? '0 : (w_pair_q & ~w_pair_clash);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge pclk_50M) begin
    if (rst) begin
      r_req_q      <= '0;
      r_stable_cnt <= '0;
    end else begin
      r_req_q <= w_req_in;
      if (w_changed)                   r_stable_cnt <= '0;
      else if (r_stable_cnt != STABLE_MAX) r_stable_cnt <= r_stable_cnt + 1'b1;
    end
  end

  always_ff @(posedge pclk_50M) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: next-state is defaulted first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_stable && (r_req_q != r_applied)) w_state_nxt = S_OFF;
      S_OFF:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_changed)                          w_state_nxt = S_IDLE;
        else if (r_settle_cnt == SETTLE_LAST)   w_state_nxt = S_ON;
      end
      S_ON:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef INTERLOCK_MAXON_EN
  localparam int W_CNT = $clog2(N_POLE + 1);
  logic [W_CNT-1:0] w_pole_cnt;
  logic             w_over;
  logic             r_conflict;

  always_comb begin
    w_pole_cnt = '0;
    for (int i = 0; i < N_POLE; i++) w_pole_cnt = w_pole_cnt + W_CNT'(w_pole_q[i]);
  end
  assign w_over   = (int'(w_pole_cnt) > MAX_ON);
  assign conflict = r_conflict;
`else
  assign conflict = 1'b0;
`endif

  // NOTE: every register here, including applied, is cleared in reset because
  // all of it feeds the drive outputs or the change comparison.
  always_ff @(posedge pclk_50M) begin
    if (rst) begin
      r_applied    <= '0;
      r_settle_cnt <= '0;
      r_pole_out   <= '0;
      r_pair_out   <= '0;
`ifdef INTERLOCK_MAXON_EN
      r_conflict   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_OFF: begin
          r_applied    <= r_req_q;
          r_settle_cnt <= '0;
          r_pair_out   <= w_pair_off;
`ifdef INTERLOCK_MAXON_EN
          r_conflict   <= w_over;
          r_pole_out   <= w_over ? '0 : (r_pole_out & w_pole_q);
`else
          r_pole_out   <= r_pole_out & w_pole_q;
`endif
        end
        S_WAIT: r_settle_cnt <= r_settle_cnt + 1'b1;
        S_ON: begin
`ifdef INTERLOCK_MAXON_EN
          r_pole_out <= r_conflict ? '0 : r_applied[W_REQ-1 -: N_POLE];
`else
          r_pole_out <= r_applied[W_REQ-1 -: N_POLE];
`endif
        end
        default: ;
      endcase
    end
  end

  assign pole_out = r_pole_out;
  assign pair_out = r_pair_out;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_interlock_out_ctrl.sv
// Self-checking bench for interlock_out_ctrl at N_POLE=4, SETTLE=10, STABLE=2.
module tb_interlock_out_ctrl;

  localparam int N_POLE = 4;
  localparam int N_PAIR = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_POLE-1:0] pole_req;
  logic [N_PAIR-1:0] pair_req;
  logic [N_POLE-1:0] pole_out;
  logic [N_PAIR-1:0] pair_out;
  logic              busy, conflict;

  always #5 clk = ~clk;

  interlock_out_ctrl #(
    .N_POLE(N_POLE), .SETTLE_CYCLES(10), .STABLE_CYCLES(2), .MAX_ON(2)
  ) dut (
    .pclk_50M(clk), .rst(rst), .pole_req(pole_req), .pair_req(pair_req),
    .pole_out(pole_out), .pair_out(pair_out), .busy(busy), .conflict(conflict)
  );

  typedef struct {
    logic [3:0] mid;
    logic [5:0] pair_exp;
    logic [3:0] fin;
    logic       cfl;
  } exp_t;

  typedef struct {
    logic [3:0] pole;
    logic [5:0] pair;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] p, input logic [5:0] q, input exp_t e);
    @(negedge clk);
    pole_req = p;
    pair_req = q;
    sb.push_back(e);
  endtask

  // Edge k counts from the first edge that samples the request.
  task automatic watch(input int first, input int last, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb[0];
    for (int k = first; k <= last; k++) begin
      @(posedge clk); #1;
      case (k)
        3: check($sformatf("%s busy@3", tag), busy, 0);
        4: check($sformatf("%s busy@4", tag), busy, 1);
        5: begin
          check($sformatf("%s pole@5", tag), pole_out, e.mid);
          check($sformatf("%s pair@5", tag), pair_out, e.pair_exp);
        end
        15: begin
          check($sformatf("%s pole@15", tag), pole_out, e.mid);
          check($sformatf("%s busy@15", tag), busy, 1);
        end
        16: begin
          check($sformatf("%s pole@16", tag), pole_out, e.fin);
          check($sformatf("%s pair@16", tag), pair_out, e.pair_exp);
          check($sformatf("%s busy@16", tag), busy, 0);
          check($sformatf("%s conflict@16", tag), conflict, e.cfl);
        end
        default: ;
      endcase
    end
    if (last == 16) e = sb.pop_front();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   busy_hits;
    int   out_bad;
    exp_t e;

    vecs[0] = '{4'b0011, 6'b111111, '{4'b0000, 6'b111110, 4'b0011, 1'b0}};
    vecs[1] = '{4'b0110, 6'b111111, '{4'b0010, 6'b111011, 4'b0110, 1'b0}};
    vecs[2] = '{4'b1001, 6'b101010, '{4'b0000, 6'b100010, 4'b1001, 1'b0}};
    vecs[3] = '{4'b0000, 6'b111111, '{4'b0000, 6'b000000, 4'b0000, 1'b0}};
    vecs[4] = '{4'b1000, 6'b100001, '{4'b0000, 6'b100001, 4'b1000, 1'b0}};
    vecs[5] = '{4'b1100, 6'b111111, '{4'b1000, 6'b011111, 4'b1100, 1'b0}};

    rst = 1'b1; pole_req = '0; pair_req = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset pole_out", pole_out, 0);
    check("reset pair_out", pair_out, 0);
    check("reset busy", busy, 0);
    check("reset conflict", conflict, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].pole, vecs[i].pair, vecs[i].e);
      watch(1, 16, $sformatf("vec%0d", i));
    end

`ifdef INTERLOCK_MAXON_EN
    drive(4'b0111, 6'b000000, '{4'b0000, 6'b000000, 4'b0000, 1'b1});
    watch(1, 16, "maxon_over");
    drive(4'b0001, 6'b000000, '{4'b0000, 6'b000000, 4'b0001, 1'b0});
    watch(1, 16, "maxon_clear");
`else
    drive(4'b0111, 6'b000000, '{4'b0100, 6'b000000, 4'b0111, 1'b0});
    watch(1, 16, "three_on");
    drive(4'b0001, 6'b000000, '{4'b0001, 6'b000000, 4'b0001, 1'b0});
    watch(1, 16, "one_on");
`endif

    // Toggling input never settles; returning to the applied value is a no-op.
    busy_hits = 0;
    out_bad   = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i < 20 && (i % 2) == 0) begin
        pole_req = 4'b1110; pair_req = 6'b111111;
      end else begin
        pole_req = 4'b0001; pair_req = 6'b000000;
      end
      @(posedge clk); #1;
      if (busy) busy_hits++;
      if (pole_out !== 4'b0001 || pair_out !== 6'b000000) out_bad++;
    end
    check("toggle busy_cycles", busy_hits, 0);
    check("toggle out_changes", out_bad, 0);

    // Change the request during the fifth WAIT cycle.
    drive(4'b0011, 6'b000011, '{4'b0001, 6'b000010, 4'b0011, 1'b0});
    watch(1, 9, "abort_r1");
    @(negedge clk);
    pole_req = 4'b0100; pair_req = 6'b000100;
    e = sb.pop_front();
    sb.push_back('{4'b0000, 6'b000100, 4'b0100, 1'b0});
    @(posedge clk); #1;
    check("abort busy", busy, 0);
    check("abort pole_hold", pole_out, 4'b0001);
    check("abort pair_hold", pair_out, 6'b000010);
    watch(2, 16, "abort_r2");

    // Reset in the middle of WAIT, then the held request replays in full.
    drive(4'b1010, 6'b111111, '{4'b0000, 6'b101111, 4'b1010, 1'b0});
    watch(1, 7, "midwait");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midwait_rst pole_out", pole_out, 0);
    check("midwait_rst pair_out", pair_out, 0);
    check("midwait_rst busy", busy, 0);
    check("midwait_rst conflict", conflict, 0);
    @(negedge clk);
    rst = 1'b0;
    watch(1, 16, "post_reset");

    check("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
